polyeval_out_buf: RTL

Result-side receiver for the polynomial evaluator. It captures each evaluated result the core emits on its unthrottled `data_cal_out`/`data_vld_o` pair into a small FIFO, then presents results downstream through a valid/ready handshake. It also keeps a result count, an occupancy level, an almost-full warning for upstream input throttling, and a sticky overflow flag. It sits between the core's result output and the system consumer.

---
 rtl/polyeval_out_buf.sv | 89 ++++++++
 1 files changed

// File: rtl/polyeval_out_buf.sv
// polyeval_out_buf: result-side FIFO receiver for the polynomial evaluator core.
//
// Captures every result the core emits on data_cal_i/data_vld_i (no backpressure
// into the core) into a DEPTH-entry first-word-fall-through FIFO, and presents
// the head downstream through a valid/ready handshake.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   data_cal_i     result word from the core
//   data_vld_i     result strobe from the core
//   clr_i          synchronous clear of FIFO, counters and flags (beats push/pop)
//   out_data_o     head-of-FIFO result, valid while out_vld_o
//   out_vld_o      head valid
//   out_rdy_i      downstream ready
//   level_o        occupancy, 0..DEPTH
//   almost_full_o  level_o >= DEPTH-2, for upstream input throttling
//   ovf_o          sticky flag: a result was dropped because the FIFO was full
//   res_cnt_o      count of results accepted into the FIFO, wraps
module polyeval_out_buf #(
    parameter int WID_D  = 32,
    parameter int DEPTH  = 8,
    parameter int RCNT_W = 16,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WID_D-1:0]  data_cal_i,
    input  logic              data_vld_i,
    input  logic              clr_i,
    output logic [WID_D-1:0]  out_data_o,
    output logic              out_vld_o,
    input  logic              out_rdy_i,
    output logic [LVL_W-1:0]  level_o,
    output logic              almost_full_o,
    output logic              ovf_o,
    output logic [RCNT_W-1:0] res_cnt_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WID_D-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wp_q, wp_d, rp_q, rp_d;
    logic [LVL_W-1:0]  lvl_q, lvl_d;
    logic [RCNT_W-1:0] cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              full, pop, push_ok, push_bad;

    assign full     = lvl_q == LVL_W'(DEPTH);
    assign pop      = out_vld_o && out_rdy_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = data_vld_i && (!full || pop);
    assign push_bad = data_vld_i && full && !pop;

    always_comb begin
        wp_d  = clr_i ? '0 : wp_q + PTR_W'(push_ok);
        rp_d  = clr_i ? '0 : rp_q + PTR_W'(pop);
        lvl_d = clr_i ? '0 : lvl_q + LVL_W'(push_ok) - LVL_W'(pop);
        cnt_d = clr_i ? '0 : cnt_q + RCNT_W'(push_ok);
        ovf_d = clr_i ? 1'b0 : (ovf_q || push_bad);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            lvl_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Storage is deliberately not reset; only pointers and counters are.
    always_ff @(posedge clk) begin
        if (push_ok && !clr_i) mem_q[wp_q] <= data_cal_i;
    end

    assign out_vld_o     = lvl_q != '0;
    assign out_data_o    = mem_q[rp_q];
    assign level_o       = lvl_q;
    assign almost_full_o = lvl_q >= LVL_W'(DEPTH - 2);
    assign ovf_o         = ovf_q;
    assign res_cnt_o     = cnt_q;
endmodule
